// File: rtl/mmu_mem_controller_if.sv
// CPU-side mmu_* request bus and word-wide backing-memory port for mmu_mem_controller.
// master = requester/memory side, slave = the controller itself.
interface mmu_mem_controller_if #(parameter int MEM_ADDR_WIDTH = 16);
  logic                      mmu_read_enable;
  logic                      mmu_write_enable;
  logic                      mmu_mem_signed_read;
  logic [1:0]                mmu_mem_data_width;
  logic [31:0]               mmu_address;
  logic [31:0]               mmu_data_in;
  logic                      mmu_mem_ready;
  logic [31:0]               mmu_data_out;
  logic                      mmu_misaligned;
  logic                      mem_req;
  logic                      mem_we;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]               mem_wdata;
  logic [3:0]                mem_wstrb;
  logic                      mem_ack;
  logic [31:0]               mem_rdata;

  modport master (
    output mmu_read_enable, mmu_write_enable, mmu_mem_signed_read, mmu_mem_data_width,
           mmu_address, mmu_data_in, mem_ack, mem_rdata,
    input  mmu_mem_ready, mmu_data_out, mmu_misaligned,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    input  mmu_read_enable, mmu_write_enable, mmu_mem_signed_read, mmu_mem_data_width,
           mmu_address, mmu_data_in, mem_ack, mem_rdata,
    output mmu_mem_ready, mmu_data_out, mmu_misaligned,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mmu_mem_controller.sv
// Byte/half/word mmu_* requests -> word transactions with strobes, aligned/extended read data.
// MMU_MISALIGNED_SPLIT_EN: split word-crossing accesses in two; otherwise reject them as misaligned.
module mmu_mem_controller #(
  parameter int MEM_ADDR_WIDTH = 16
) (
  input logic               clk,
  input logic               reset_n,
  mmu_mem_controller_if.slave bus
);

`ifdef MMU_MISALIGNED_SPLIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, DONE = 2'd2, ACC1 = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, DONE = 2'd2} state_e;
`endif

  state_e                    state_q, state_d;
  logic                      ready_q, ready_d;
  logic                      misaligned_q, misaligned_d;
  logic [31:0]               data_out_q, data_out_d;
  logic                      mem_req_q, mem_req_d;
  logic                      mem_we_q, mem_we_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]               mem_wdata_q, mem_wdata_d;
  logic [3:0]                mem_wstrb_q, mem_wstrb_d;
  logic [1:0]                off_q, off_d;
  logic [1:0]                width_q, width_d;
  logic                      signed_q, signed_d;
  logic                      we_q, we_d;

  logic [1:0]  off;
  logic [3:0]  mask;
  logic [3:0]  wstrb_lo;
  logic [31:0] wdata_lo;
  logic        split;
  logic        unused_addr;

  assign off         = bus.mmu_address[1:0];
  assign unused_addr = ^bus.mmu_address[31:MEM_ADDR_WIDTH+2];

  always_comb begin
    case (bus.mmu_mem_data_width)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
  end

  assign split = ((bus.mmu_mem_data_width == 2'b01) && (off == 2'd3)) ||
                 (bus.mmu_mem_data_width[1] && (off != 2'd0));

`ifdef MMU_MISALIGNED_SPLIT_EN
  logic [3:0]  wstrb_hi, wstrb_hi_q, wstrb_hi_d;
  logic [31:0] wdata_hi, wdata_hi_q, wdata_hi_d;
  logic [31:0] rd0_q, rd0_d;
  logic        split_q, split_d;
  assign {wdata_hi, wdata_lo} = {32'b0, bus.mmu_data_in} << {off, 3'b000};
  assign {wstrb_hi, wstrb_lo} = {4'b0, mask} << off;
`else
  assign wdata_lo = bus.mmu_data_in << {off, 3'b000};
  assign wstrb_lo = mask << off;
`endif

  // Little-endian extract from {word1, word0}, then truncate and extend to 32 bits.
  function automatic logic [31:0] extract(input logic [63:0] words, input logic [1:0] o,
                                          input logic [1:0] w, input logic sg);
    logic [31:0] sh;
    sh = 32'(words >> {o, 3'b000});
    case (w)
      2'b00:   extract = {{24{sg & sh[7]}}, sh[7:0]};
      2'b01:   extract = {{16{sg & sh[15]}}, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    ready_d      = 1'b0;
    misaligned_d = 1'b0;
    data_out_d   = data_out_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    off_d        = off_q;
    width_d      = width_q;
    signed_d     = signed_q;
    we_d         = we_q;
`ifdef MMU_MISALIGNED_SPLIT_EN
    wstrb_hi_d   = wstrb_hi_q;
    wdata_hi_d   = wdata_hi_q;
    rd0_d        = rd0_q;
    split_d      = split_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.mmu_write_enable || bus.mmu_read_enable) begin
          off_d      = off;
          width_d    = bus.mmu_mem_data_width;
          signed_d   = bus.mmu_mem_signed_read;
          we_d       = bus.mmu_write_enable;
          mem_addr_d = bus.mmu_address[MEM_ADDR_WIDTH+1:2];
`ifdef MMU_MISALIGNED_SPLIT_EN
          split_d     = split;
          wstrb_hi_d  = wstrb_hi;
          wdata_hi_d  = wdata_hi;
          state_d     = ACC0;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.mmu_write_enable;
          mem_wstrb_d = wstrb_lo;
          mem_wdata_d = wdata_lo;
`else
          if (split) begin
            // Rejected: no memory traffic, complete immediately with zero data.
            state_d      = DONE;
            ready_d      = 1'b1;
            misaligned_d = 1'b1;
            data_out_d   = 32'h0;
          end else begin
            state_d     = ACC0;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.mmu_write_enable;
            mem_wstrb_d = wstrb_lo;
            mem_wdata_d = wdata_lo;
          end
`endif
        end
      end
      ACC0: begin
        if (bus.mem_ack) begin
`ifdef MMU_MISALIGNED_SPLIT_EN
          rd0_d = bus.mem_rdata;
          if (split_q) begin
            state_d     = ACC1;
            mem_addr_d  = mem_addr_q + 1'b1;
            mem_wstrb_d = wstrb_hi_q;
            mem_wdata_d = wdata_hi_q;
          end else
`endif
          begin
            state_d   = DONE;
            ready_d   = 1'b1;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            if (!we_q) data_out_d = extract({32'h0, bus.mem_rdata}, off_q, width_q, signed_q);
          end
        end
      end
`ifdef MMU_MISALIGNED_SPLIT_EN
      ACC1: begin
        if (bus.mem_ack) begin
          state_d   = DONE;
          ready_d   = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!we_q) data_out_d = extract({bus.mem_rdata, rd0_q}, off_q, width_q, signed_q);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      misaligned_q <= 1'b0;
      data_out_q   <= 32'h0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      mem_wstrb_q  <= 4'h0;
      off_q        <= 2'd0;
      width_q      <= 2'd0;
      signed_q     <= 1'b0;
      we_q         <= 1'b0;
`ifdef MMU_MISALIGNED_SPLIT_EN
      wstrb_hi_q   <= 4'h0;
      wdata_hi_q   <= 32'h0;
      rd0_q        <= 32'h0;
      split_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      misaligned_q <= misaligned_d;
      data_out_q   <= data_out_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      off_q        <= off_d;
      width_q      <= width_d;
      signed_q     <= signed_d;
      we_q         <= we_d;
`ifdef MMU_MISALIGNED_SPLIT_EN
      wstrb_hi_q   <= wstrb_hi_d;
      wdata_hi_q   <= wdata_hi_d;
      rd0_q        <= rd0_d;
      split_q      <= split_d;
`endif
    end
  end

  assign bus.mmu_mem_ready  = ready_q;
  assign bus.mmu_misaligned = misaligned_q;
  assign bus.mmu_data_out   = data_out_q;
  assign bus.mem_req        = mem_req_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.mem_wstrb      = mem_wstrb_q;

endmodule

// File: tb/tb_mmu_mem_controller.sv
// Directed bench for mmu_mem_controller with a strobed word memory model and configurable ack wait.
module tb_mmu_mem_controller;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mmu_mem_controller_if #(.MEM_ADDR_WIDTH(16)) bus ();
  mmu_mem_controller #(.MEM_ADDR_WIDTH(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  logic [31:0] mem [0:255];
  int          wait_n = 0;
  int          wcnt = 0;
  logic        force_ack = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          nx = 0;
  logic [15:0] log_addr [0:3];
  logic [3:0]  log_strb [0:3];
  logic [31:0] log_wdata [0:3];
  logic        log_we [0:3];

  assign bus.mem_ack   = (bus.mem_req && (wcnt >= wait_n)) || force_ack;
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  // Memory model: commits strobed writes and logs every accepted transaction.
  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_ack) begin
      if (nx < 4) begin
        log_addr[nx] = bus.mem_addr; log_strb[nx] = bus.mem_wstrb;
        log_wdata[nx] = bus.mem_wdata; log_we[nx] = bus.mem_we;
      end
      nx = nx + 1;
      if (bus.mem_we)
        for (int b = 0; b < 4; b++)
          if (bus.mem_wstrb[b]) mem[bus.mem_addr[7:0]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
    end
    if (bus.mem_req && !bus.mem_ack) wcnt = wcnt + 1;
    else wcnt = 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request; lat counts edges after the sampling edge until ready is seen.
  task automatic xact(input logic w, input logic r, input logic sg, input logic [1:0] wd,
                      input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic mis);
    @(negedge clk);
    nx = 0;
    bus.mmu_write_enable = w; bus.mmu_read_enable = r; bus.mmu_mem_signed_read = sg;
    bus.mmu_mem_data_width = wd; bus.mmu_address = a; bus.mmu_data_in = d;
    @(posedge clk); #1;
    lat = 0;
    while (!bus.mmu_mem_ready && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 50) chk("ready_timeout", 32'(lat), 32'd0);
    mis = bus.mmu_misaligned;
    bus.mmu_write_enable = 1'b0; bus.mmu_read_enable = 1'b0;
    @(posedge clk);
  endtask

  int          lat;
  logic        mis;
  logic [31:0] exp_out;
  int          nx_save;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    bus.mmu_write_enable = 1'b0; bus.mmu_read_enable = 1'b0; bus.mmu_mem_signed_read = 1'b0;
    bus.mmu_mem_data_width = 2'b10; bus.mmu_address = 32'h0; bus.mmu_data_in = 32'h0;
    #2;
    chk("rst_ready", 32'(bus.mmu_mem_ready), 32'd0);
    chk("rst_misal", 32'(bus.mmu_misaligned), 32'd0);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_dout", bus.mmu_data_out, 32'h0);
    chk("rst_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_wstrb", 32'(bus.mem_wstrb), 32'h0);
    @(negedge clk); reset_n = 1'b1;

    // Word write then readback
    xact(1, 0, 0, 2'b10, 32'h100, 32'hDEADBEEF, lat, mis);
    chk("ww_lat", 32'(lat), 32'd1);
    chk("ww_nx", 32'(nx), 32'd1);
    chk("ww_addr", 32'(log_addr[0]), 32'h40);
    chk("ww_strb", 32'(log_strb[0]), 32'hF);
    chk("ww_wdata", log_wdata[0], 32'hDEADBEEF);
    chk("ww_we", 32'(log_we[0]), 32'd1);
    chk("ww_dout", bus.mmu_data_out, 32'h0);
    xact(0, 1, 0, 2'b10, 32'h100, 32'h0, lat, mis);
    chk("wr_lat", 32'(lat), 32'd1);
    chk("wr_data", bus.mmu_data_out, 32'hDEADBEEF);

    // Sub-word reads with extension
    xact(0, 1, 1, 2'b00, 32'h103, 32'h0, lat, mis);
    chk("rb_s", bus.mmu_data_out, 32'hFFFFFFDE);
    xact(0, 1, 0, 2'b00, 32'h103, 32'h0, lat, mis);
    chk("rb_u", bus.mmu_data_out, 32'h000000DE);
    xact(0, 1, 1, 2'b01, 32'h100, 32'h0, lat, mis);
    chk("rh_s", bus.mmu_data_out, 32'hFFFFBEEF);

    // Half write into upper lanes
    xact(1, 0, 0, 2'b01, 32'h102, 32'h00001234, lat, mis);
    chk("hw_strb", 32'(log_strb[0]), 32'hC);
    chk("hw_wdata", log_wdata[0], 32'h12340000);
    chk("hw_dout", bus.mmu_data_out, 32'hFFFFBEEF);
    xact(0, 1, 0, 2'b10, 32'h100, 32'h0, lat, mis);
    chk("hw_rd", bus.mmu_data_out, 32'h1234BEEF);

    // Word-crossing read
    mem[8'h40] = 32'h44332211; mem[8'h41] = 32'h88776655;
    xact(0, 1, 0, 2'b10, 32'h101, 32'h0, lat, mis);
`ifdef MMU_MISALIGNED_SPLIT_EN
    chk("sp_nx", 32'(nx), 32'd2);
    chk("sp_a0", 32'(log_addr[0]), 32'h40);
    chk("sp_a1", 32'(log_addr[1]), 32'h41);
    chk("sp_lat", 32'(lat), 32'd2);
    chk("sp_mis", 32'(mis), 32'd0);
    chk("sp_data", bus.mmu_data_out, 32'h55443322);
    exp_out = 32'h55443322;
`else
    chk("mis_nx", 32'(nx), 32'd0);
    chk("mis_lat", 32'(lat), 32'd0);
    chk("mis_flag", 32'(mis), 32'd1);
    chk("mis_data", bus.mmu_data_out, 32'h0);
    exp_out = 32'h0;
`endif

    // Both enables: write wins
    xact(1, 1, 0, 2'b10, 32'h108, 32'hCAFEF00D, lat, mis);
    chk("both_we", 32'(log_we[0]), 32'd1);
    chk("both_mem", mem[8'h42], 32'hCAFEF00D);
    chk("both_dout", bus.mmu_data_out, exp_out);

    // Crossing half write at offset 3
    xact(1, 0, 0, 2'b01, 32'h10B, 32'h0000A5B6, lat, mis);
`ifdef MMU_MISALIGNED_SPLIT_EN
    chk("shw_strb0", 32'(log_strb[0]), 32'h8);
    chk("shw_wd0", log_wdata[0], 32'hB6000000);
    chk("shw_strb1", 32'(log_strb[1]), 32'h1);
    chk("shw_wd1", log_wdata[1], 32'h000000A5);
    chk("shw_m42", mem[8'h42], 32'hB6FEF00D);
    chk("shw_m43", mem[8'h43], 32'h000000A5);
`else
    chk("shw_mis", 32'(mis), 32'd1);
    chk("shw_m42", mem[8'h42], 32'hCAFEF00D);
`endif

    // Wait states
    wait_n = 2;
    xact(0, 1, 0, 2'b10, 32'h100, 32'h0, lat, mis);
    chk("wait_lat", 32'(lat), 32'd3);
    chk("wait_data", bus.mmu_data_out, 32'h44332211);

    // Reset during ACC0 with a slow memory
    wait_n = 5;
    @(negedge clk);
    bus.mmu_read_enable = 1'b1; bus.mmu_mem_data_width = 2'b10; bus.mmu_address = 32'h104;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    chk("acc0_req", 32'(bus.mem_req), 32'd1);
    @(negedge clk); reset_n = 1'b0; #1;
    chk("ar_req", 32'(bus.mem_req), 32'd0);
    chk("ar_we", 32'(bus.mem_we), 32'd0);
    chk("ar_ready", 32'(bus.mmu_mem_ready), 32'd0);
    chk("ar_dout", bus.mmu_data_out, 32'h0);
    chk("ar_addr", 32'(bus.mem_addr), 32'h0);
    chk("ar_wstrb", 32'(bus.mem_wstrb), 32'h0);
    bus.mmu_read_enable = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    nx_save = nx;
    force_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("late_ready", 32'(bus.mmu_mem_ready), 32'd0);
    end
    force_ack = 1'b0;
    chk("late_nx", 32'(nx), 32'(nx_save));
    wait_n = 0;
    xact(0, 1, 0, 2'b10, 32'h108, 32'h0, lat, mis);
    chk("post_lat", 32'(lat), 32'd1);
`ifdef MMU_MISALIGNED_SPLIT_EN
    chk("post_data", bus.mmu_data_out, 32'hB6FEF00D);
`else
    chk("post_data", bus.mmu_data_out, 32'hCAFEF00D);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmu_mem_controller.md
# mmu_mem_controller

Memory-side responder for the CPU's `mmu_*` request interface. It accepts one read or write request at a time with byte, half or word width. It translates the request into word-wide transactions with byte strobes on a generic backing-memory port, then returns `mmu_mem_ready` with aligned, sign- or zero-extended read data. The block sits between the CPU core and on-chip RAM, and absorbs variable memory latency through an ack handshake.

## Interface
- `MEM_ADDR_WIDTH`, default 16: width of the word address on the memory port. Byte address bits `[MEM_ADDR_WIDTH+1:2]` are used; upper bits are ignored, so addresses wrap.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mmu_read_enable` in 1: read request.
- `mmu_write_enable` in 1: write request; has priority over read.
- `mmu_mem_signed_read` in 1: sign-extend byte/half read data.
- `mmu_mem_data_width` in 2: `MMU_WIDTH_BYTE`=00, `MMU_WIDTH_HALF`=01, `MMU_WIDTH_WORD`=10; 11 is treated as word.
- `mmu_address` in 32: byte address.
- `mmu_data_in` in 32: write data, right-aligned.
- `mmu_mem_ready` out 1: one-cycle completion pulse.
- `mmu_data_out` out 32: read result; held until the next read completes.
- `mmu_misaligned` out 1: pulses with `mmu_mem_ready` on a rejected misaligned access.
- `mem_req` out 1: memory transaction request; held until `mem_ack`.
- `mem_we` out 1: transaction is a write.
- `mem_addr` out `MEM_ADDR_WIDTH`: word address.
- `mem_wdata` out 32: write data, lane-aligned.
- `mem_wstrb` out 4: byte write strobes.
- `mem_ack` in 1: transaction done; `mem_rdata` is valid in the same cycle for reads.
- `mem_rdata` in 32: read data.

## Operation
- The FSM has four states: IDLE, ACC0, ACC1, DONE.
- In IDLE, if `mmu_write_enable` or `mmu_read_enable` is high at a rising edge, the block latches address, width, signed flag, data and direction, and moves to ACC0.
  - `mem_req` is registered high on the same edge.
  - If both enables are high, the write is performed and the read is dropped.
- In ACC0, `mem_req` is held with stable `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` until `mem_ack`.
  - On `mem_ack`, read data is captured.
  - If the access crosses a word boundary, the block goes to ACC1 and issues the next word address, which is `mem_addr`+1 with wrap.
  - Otherwise the block goes to DONE.
- In ACC1, the second word is transferred in the same way; on `mem_ack` the block goes to DONE.
- In DONE, `mmu_mem_ready` is 1 for this cycle only, `mmu_data_out` takes its new value, and the next state is IDLE.
- Byte offset `o = mmu_address[1:0]`.
- Lane mask is `0001` (byte), `0011` (half) or `1111` (word).
- Write data path:
  - `mem_wstrb = (mask << o)[3:0]` and `mem_wdata = (data << 8*o)[31:0]`.
  - On a split write, the second word uses `(mask << o)[7:4]` and `(data << 8*o)[63:32]`.
- Read data path:
  - Read is little-endian: `{word1, word0} >> 8*o`.
  - The result is truncated to the access width, then sign-extended if `mmu_mem_signed_read`, else zero-extended.
- Split condition: half at `o`=3, or word at `o`≠0. Byte accesses never split.
- After a write, `mmu_data_out` is unchanged.
- `mem_ack` outside ACC0/ACC1 is ignored.

## Timing
- Reset values: state IDLE; `mmu_mem_ready`, `mmu_misaligned`, `mem_req` and `mem_we` are 0; `mmu_data_out`, `mem_addr`, `mem_wdata` and `mem_wstrb` are 0.
- Reset mid-operation: outputs clear immediately and asynchronously, the transaction is abandoned, and a late `mem_ack` is ignored.
- Latency with zero-wait memory (`mem_ack` in the first `mem_req` cycle):
  - Request sampled at edge n.
  - `mmu_mem_ready` is high in the cycle after edge n+1 for a single access, and after edge n+2 for a split access.
  - Each memory wait cycle adds one cycle.
- Throughput: minimum 3 cycles per single access, because IDLE always lasts at least one cycle after DONE.
- The requester must hold `mmu_*` inputs stable until `mmu_mem_ready`. The block samples them only in IDLE.

## Configuration
- `MMU_MISALIGNED_SPLIT_EN` defined: boundary-crossing accesses are split into two memory transactions as described above.
- Undefined:
  - A boundary-crossing access issues no `mem_req` and goes from IDLE to DONE directly.
  - In DONE, `mmu_mem_ready` and `mmu_misaligned` are both 1 and `mmu_data_out` becomes 0. Memory is not modified.
  - The ACC1 state is not compiled in.

## Test plan
- Word write of 0xDEADBEEF to 0x100, zero-wait memory -> one `mem_req`, `mem_addr`=0x40, `mem_wstrb`=1111; ready one cycle after edge n+1. A following word read returns 0xDEADBEEF.
- Memory word 0x100 = 0xDEADBEEF; signed byte read at 0x103 -> 0xFFFFFFDE; unsigned -> 0x000000DE; signed half read at 0x100 -> 0xFFFFBEEF.
- Half write of 0x1234 at 0x102 -> `mem_wstrb`=1100, `mem_wdata`=0x12340000. A word read of 0x100 then returns 0x1234BEEF.
- Words 0x100=0x44332211 and 0x104=0x88776655; word read at 0x101:
  - With macro: `mem_addr` 0x40 then 0x41, `mmu_data_out`=0x55443322.
  - Without macro: no `mem_req`, `mmu_misaligned`=1, `mmu_data_out`=0.
- Both enables high with address 0x108 and data 0xCAFEF00D -> `mem_we`=1, memory is written, and `mmu_data_out` is unchanged.
- `mem_ack` delayed 5 cycles, then `reset_n` pulsed low in ACC0 -> all outputs are 0 immediately, and a late `mem_ack` is ignored. The next request completes normally.
